// File: rtl/mult_hazard_control_unit_if.sv
// ID-stage control bus: instruction fields in, datapath controls and MUL handshake out.
interface mult_hazard_control_unit_if;
  logic       instr_valid;
  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       branch_taken;
  logic       flush_in;
  logic [1:0] alu_op;
  logic       reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump;
  logic       flush, mul_sel, mul_start, mul_done, stall, busy;

  modport master (
    output instr_valid, opcode, funct7, branch_taken, flush_in,
    input  alu_op, reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump,
    input  flush, mul_sel, mul_start, mul_done, stall, busy
  );

  modport slave (
    input  instr_valid, opcode, funct7, branch_taken, flush_in,
    output alu_op, reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump,
    output flush, mul_sel, mul_start, mul_done, stall, busy
  );
endinterface

// File: rtl/mult_hazard_control_unit.sv
// Decode-stage control: opcode decode, branch/jump flush, and a MUL sequencer that
// holds the MUL in ID for MUL_LATENCY cycles while the multiplier runs.
module mult_hazard_control_unit #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 4,
  parameter bit ENABLE_MUL  = 1'b1
) (
  input  logic clk,
  input  logic arst_n,
  mult_hazard_control_unit_if.slave bus
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_2_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            dec, ctrl, mul_ctrl, bubble;
  logic             is_mul, live;
  logic             flush_d, sel_d, start_d, done_d, stall_d;

  always_comb begin
    dec        = '0;
    dec.alu_op = 2'b10;
    case (bus.opcode)
      OP_R:  dec.reg_write = 1'b1;
      OP_I:  begin dec.alu_op = 2'b00; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
      OP_BR: begin dec.alu_op = 2'b01; dec.branch = 1'b1; end
      OP_J:  begin dec.alu_op = 2'b00; dec.reg_write = 1'b1; dec.jump = 1'b1; end
      OP_LD: begin
        dec.alu_op = 2'b00; dec.alu_src = 1'b1; dec.mem_2_reg = 1'b1;
        dec.reg_write = 1'b1; dec.mem_read = 1'b1;
      end
      OP_ST: begin dec.alu_op = 2'b00; dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
      default: ;
    endcase
  end

  // MUL controls are fixed: the frozen IF/ID means the opcode seen in BUSY is not trusted.
  always_comb begin
    mul_ctrl           = '0;
    mul_ctrl.alu_op    = 2'b10;
    mul_ctrl.reg_write = 1'b1;
    bubble             = mul_ctrl;
    bubble.reg_write   = 1'b0;
  end

  assign is_mul = ENABLE_MUL && (bus.opcode == OP_R) && (bus.funct7 == 7'b0000001);
  assign live   = arst_n && bus.instr_valid && !bus.flush_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = '0;
    flush_d = 1'b0;
    sel_d   = 1'b0;
    start_d = 1'b0;
    done_d  = 1'b0;
    stall_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (live) begin
          if (is_mul) begin
            start_d = 1'b1;
            if (MUL_LATENCY == 1) begin
              ctrl   = mul_ctrl;
              sel_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              ctrl    = bubble;
              stall_d = 1'b1;
              state_d = BUSY;
              cnt_d   = CNT_W'(MUL_LATENCY - 1);
            end
          end else begin
            ctrl    = dec;
            flush_d = (dec.branch && bus.branch_taken) || dec.jump;
          end
        end
      end
      BUSY: begin
        if (arst_n && bus.flush_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (live) begin
          if (cnt_q > CNT_W'(1)) begin
            ctrl    = bubble;
            stall_d = 1'b1;
            cnt_d   = cnt_q - CNT_W'(1);
          end else begin
            ctrl    = mul_ctrl;
            sel_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.alu_op    = ctrl.alu_op;
  assign bus.reg_dst   = 1'b0;
  assign bus.branch    = ctrl.branch;
  assign bus.mem_read  = ctrl.mem_read;
  assign bus.mem_2_reg = ctrl.mem_2_reg;
  assign bus.mem_write = ctrl.mem_write;
  assign bus.alu_src   = ctrl.alu_src;
  assign bus.reg_write = ctrl.reg_write;
  assign bus.jump      = ctrl.jump;
  assign bus.flush     = flush_d;
  assign bus.mul_sel   = sel_d;
  assign bus.mul_start = start_d;
  assign bus.mul_done  = done_d;
  assign bus.stall     = stall_d;
  assign bus.busy      = (state_q == BUSY);

endmodule

// File: tb/tb_mult_hazard_control_unit.sv
// Directed bench: a MUL_LATENCY=4 and a MUL_LATENCY=1 unit share one stimulus stream.
module tb_mult_hazard_control_unit;

  localparam logic [15:0] BSY = 16'h0001, ST  = 16'h0002, MD  = 16'h0004, MS  = 16'h0008;
  localparam logic [15:0] SEL = 16'h0010, FL  = 16'h0020, J   = 16'h0040, RW  = 16'h0080;
  localparam logic [15:0] AS  = 16'h0100, MW  = 16'h0200, M2R = 16'h0400, MR  = 16'h0800;
  localparam logic [15:0] BR  = 16'h1000, OP10 = 16'h8000, OP01 = 16'h4000;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111, LD = 7'b0000011, STO = 7'b0100011;
  localparam logic [6:0] MULF = 7'b0000001;

  localparam logic [15:0] E_ADD = OP10 | RW;
  localparam logic [15:0] E_C0  = OP10 | MS | ST;
  localparam logic [15:0] E_C12 = OP10 | ST | BSY;
  localparam logic [15:0] E_C3  = OP10 | RW | SEL | MD | BSY;
  localparam logic [15:0] E_L1  = OP10 | RW | SEL | MS | MD;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       iv, bt, fl;
  logic [6:0] op, f7;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  mult_hazard_control_unit_if if4 ();
  mult_hazard_control_unit_if if1 ();

  assign if4.instr_valid = iv;  assign if1.instr_valid = iv;
  assign if4.opcode = op;       assign if1.opcode = op;
  assign if4.funct7 = f7;       assign if1.funct7 = f7;
  assign if4.branch_taken = bt; assign if1.branch_taken = bt;
  assign if4.flush_in = fl;     assign if1.flush_in = fl;

  mult_hazard_control_unit #(.MUL_LATENCY(4), .CNT_W(4), .ENABLE_MUL(1'b1)) u_l4 (
    .clk(clk), .arst_n(arst_n), .bus(if4)
  );
  mult_hazard_control_unit #(.MUL_LATENCY(1), .CNT_W(4), .ENABLE_MUL(1'b1)) u_l1 (
    .clk(clk), .arst_n(arst_n), .bus(if1)
  );

  logic [15:0] v4, v1;
  assign v4 = {if4.alu_op, if4.reg_dst, if4.branch, if4.mem_read, if4.mem_2_reg, if4.mem_write,
               if4.alu_src, if4.reg_write, if4.jump, if4.flush, if4.mul_sel, if4.mul_start,
               if4.mul_done, if4.stall, if4.busy};
  assign v1 = {if1.alu_op, if1.reg_dst, if1.branch, if1.mem_read, if1.mem_2_reg, if1.mem_write,
               if1.alu_src, if1.reg_write, if1.jump, if1.flush, if1.mul_sel, if1.mul_start,
               if1.mul_done, if1.stall, if1.busy};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply inputs just after a falling edge and let them settle before checking.
  task automatic drive(input logic v, input logic [6:0] o, input logic [6:0] f,
                       input logic b, input logic k);
    @(negedge clk);
    iv = v; op = o; f7 = f; bt = b; fl = k;
    #2;
  endtask

  typedef struct {
    string      tag;
    logic       v;
    logic [6:0] o;
    logic       b;
    logic       k;
    logic [15:0] e;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{"addi",    1'b1, I,        1'b0, 1'b0, AS | RW};
    tbl[1]  = '{"beq_t",   1'b1, BEQ,      1'b1, 1'b0, OP01 | BR | FL};
    tbl[2]  = '{"beq_nt",  1'b1, BEQ,      1'b0, 1'b0, OP01 | BR};
    tbl[3]  = '{"jal",     1'b1, JAL,      1'b0, 1'b0, J | RW | FL};
    tbl[4]  = '{"load",    1'b1, LD,       1'b0, 1'b0, AS | M2R | RW | MR};
    tbl[5]  = '{"store",   1'b1, STO,      1'b0, 1'b0, AS | MW};
    tbl[6]  = '{"dflt",    1'b1, 7'h7f,    1'b0, 1'b0, OP10};
    tbl[7]  = '{"add_iv0", 1'b0, R,        1'b0, 1'b0, 16'h0000};
    tbl[8]  = '{"add_fl",  1'b1, R,        1'b0, 1'b1, 16'h0000};
    tbl[9]  = '{"jal_fl",  1'b1, JAL,      1'b0, 1'b1, 16'h0000};
    tbl[10] = '{"beq_iv0", 1'b0, BEQ,      1'b1, 1'b0, 16'h0000};

    arst_n = 1'b0;
    iv = 1'b1; op = R; f7 = 7'h00; bt = 1'b0; fl = 1'b0;
    #2;
    chk("rst_l4", v4, 16'h0000);
    chk("rst_l1", v1, 16'h0000);

    @(negedge clk);
    arst_n = 1'b1;
    drive(1'b1, R, 7'h00, 1'b0, 1'b0);
    chk("add_l4", v4, E_ADD);
    chk("add_l1", v1, E_ADD);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].o, 7'h00, tbl[i].b, tbl[i].k);
      chk({tbl[i].tag, "_l4"}, v4, tbl[i].e);
      chk({tbl[i].tag, "_l1"}, v1, tbl[i].e);
    end

    // full MUL on both units
    drive(1'b1, R, MULF, 1'b0, 1'b0); chk("mul_c0", v4, E_C0);  chk("mul1_c0", v1, E_L1);
    drive(1'b1, R, MULF, 1'b0, 1'b0); chk("mul_c1", v4, E_C12); chk("mul1_c1", v1, E_L1);
    drive(1'b1, R, MULF, 1'b0, 1'b0); chk("mul_c2", v4, E_C12); chk("mul1_c2", v1, E_L1);
    drive(1'b1, R, MULF, 1'b0, 1'b0); chk("mul_c3", v4, E_C3);  chk("mul1_c3", v1, E_L1);
    drive(1'b1, R, 7'h00, 1'b0, 1'b0); chk("mul_post", v4, E_ADD);

    // abort by flush_in in cycle 2; opcode wobble in BUSY must not matter
    drive(1'b1, R, MULF, 1'b0, 1'b0); chk("ab_c0", v4, E_C0);
    drive(1'b1, LD, 7'h00, 1'b0, 1'b0); chk("ab_c1_op", v4, E_C12);
    drive(1'b1, R, MULF, 1'b0, 1'b1);
    chk("ab_c2_l4", v4 & ~BSY, 16'h0000);
    chk("ab_c2_l1", v1, 16'h0000);
    drive(1'b1, R, 7'h00, 1'b0, 1'b0); chk("ab_add", v4, E_ADD);

    // async reset in cycle 1, then restart and back-to-back MULs
    drive(1'b1, R, MULF, 1'b0, 1'b0); chk("rs_c0", v4, E_C0);
    @(negedge clk);
    arst_n = 1'b0;
    #2;
    chk("rs_mid_l4", v4, 16'h0000);
    chk("rs_mid_l1", v1, 16'h0000);
    @(negedge clk);
    arst_n = 1'b1;
    #2;
    chk("rs_restart", v4, E_C0);
    drive(1'b1, R, MULF, 1'b0, 1'b0); chk("bb_c1", v4, E_C12);
    drive(1'b1, R, MULF, 1'b0, 1'b0); chk("bb_c2", v4, E_C12);
    drive(1'b1, R, MULF, 1'b0, 1'b0); chk("bb_c3", v4, E_C3);
    drive(1'b1, R, MULF, 1'b0, 1'b0); chk("bb2_c0", v4, E_C0);
    drive(1'b1, R, MULF, 1'b0, 1'b0); chk("bb2_c1", v4, E_C12);

    @(negedge clk);
    arst_n = 1'b0;
    #2;
    chk("end_rst", v4, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_hazard_control_unit.md
Name: mult_hazard_control_unit

Overview:
- Decode-stage control unit for the pipelined RISC-V core. It extends the single-cycle opcode decoder with a parametrised multi-cycle MUL sequencer.
- It decodes opcode/funct7 into datapath controls and generates taken-branch/jump flush.
- For MUL (R-type, funct7=0000001) it holds the instruction in ID for MUL_LATENCY cycles: it stalls IF/ID, bubbles ID/EX, and handshakes with the multiplier.

Parameters:
- MUL_LATENCY, 4, cycles the multiplier needs; legal 1..15.
- CNT_W, 4, counter width; must be >= clog2(MUL_LATENCY+1).
- ENABLE_MUL, 1, when 0 MUL decodes as a plain R-type (mul_sel=0) and the sequencer never leaves IDLE.

Ports:
- clk  in  1  core clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  ID stage holds a valid instruction.
- opcode  in  7  instr[6:0].
- funct7  in  7  instr[31:25].
- branch_taken  in  1  branch comparison result for the ID instruction.
- flush_in  in  1  kill from a later stage; discards the ID instruction.
- alu_op  out  2  00 add, 01 sub, 10 R-type.
- reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump  out  1 each  datapath controls.
- flush  out  1  flush IF/ID (taken branch or jump).
- mul_sel  out  1  EX selects the multiplier result.
- mul_start  out  1  one-cycle pulse that launches the multiplier.
- mul_done  out  1  one-cycle pulse in the cycle the MUL issues to EX.
- stall  out  1  freeze PC and IF/ID.
- busy  out  1  sequencer not IDLE.

Behaviour:
- Reset: while arst_n=0, state=IDLE and cnt=0. Every output is forced to 0 combinationally for as long as arst_n is low.
- Decode is combinational. Rows are alu_src/mem_2_reg/reg_write/mem_read/mem_write/branch/alu_op/jump:
  - ALU_R 0110011: 0/0/1/0/0/0/10/0.
  - ALU_I 0010011: 1/0/1/0/0/0/00/0.
  - BRANCH 1100011: 0/0/0/0/0/1/01/0; flush=branch_taken.
  - JAL 1101111: 0/0/1/0/0/0/00/1; flush=1.
  - LOAD 0000011: 1/1/1/1/0/0/00/0.
  - STORE 0100011: 1/0/0/0/1/0/00/0.
  - default: all 0, alu_op=10.
  - reg_dst=0 always. No X outputs are permitted.
- Gating: instr_valid=0 or flush_in=1 forces all decode outputs, flush, mul_start, mul_done and stall to 0.
- is_mul = ENABLE_MUL && opcode=0110011 && funct7=0000001. mul_sel = is_mul in the issue cycle only.
- FSM states are IDLE and BUSY. cnt counts remaining cycles.
- IDLE, valid is_mul:
  - mul_start=1.
  - If MUL_LATENCY=1: mul_done=1, stall=0, full controls issue, stay IDLE.
  - Else: stall=1, ID/EX bubble (reg_write, mem_write, mem_read, branch, jump, mul_sel all 0), go to BUSY with cnt=MUL_LATENCY-1.
- BUSY, cnt>1: stall=1, bubble, cnt decrements.
- BUSY, cnt=1 (issue cycle): stall=0, mul_done=1, full MUL controls with mul_sel=1, go to IDLE.
- Total MUL residence in ID is exactly MUL_LATENCY cycles. stall is high for MUL_LATENCY-1 of them.
- mul_start never fires in BUSY.
- flush_in in BUSY: abort. Next state is IDLE, cnt=0, no mul_done. Outputs are zero in that cycle.
- Back-to-back MUL: the second MUL is seen in IDLE the cycle after issue and starts a new sequence with no idle gap.
- Opcode changes while BUSY are ignored, because the IF/ID register is frozen upstream. The sequencer holds its state regardless.
- Async reset mid-BUSY: immediate return to IDLE. No mul_done is produced.
- busy = (state==BUSY).

Test Plan:
- Reset, then add (0110011, funct7=0) with instr_valid=1 -> reg_write=1, alu_op=10, stall=0, busy=0, no mul pulses.
- MUL_LATENCY=4, one MUL held valid ->
  - mul_start in cycle 0.
  - stall=1 in cycles 0-2, with reg_write=0 there.
  - Cycle 3: stall=0, mul_done=1, mul_sel=1, reg_write=1.
  - busy=1 in cycles 1-3.
- MUL_LATENCY=1 -> mul_start=mul_done=1 in the same cycle, stall never asserts, busy stays 0.
- BEQ with branch_taken=1 -> branch=1, alu_op=01, flush=1. With branch_taken=0 -> flush=0. JAL -> jump=1, flush=1.
- MUL (L=4), flush_in=1 in cycle 2 -> outputs 0 that cycle, IDLE next cycle, no mul_done. A following add decodes normally.
- MUL (L=4), arst_n pulsed low in cycle 1 -> all outputs 0 immediately, busy=0. After release, MUL restarts with mul_start. Back-to-back MULs -> mul_done, then mul_start on the next cycle.
